alu_issue: RTL

- Issue stage directly upstream of the ALU for the RV32I OP and OP-IMM classes.
- Accepts one instruction word from fetch and decodes it to the ALU's one-hot operation flags.
- Reads operands from an external combinational-read register file, drives the ALU valid/ready handshake and collects the result.
- Presents the result to writeback as a single-cycle pulse.

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/alu_decoder.sv | 85 ++++++++
 rtl/alu_issue.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the ALU issue stage.
//   - RV32I opcode, funct3 and funct7 encodings used by the OP/OP-IMM decoder
//   - issue_state_t: issue-stage FSM states
//   - alu_op_t: one-hot ALU operation flags, one bit per supported operation
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WB    = 2'd3
    } issue_state_t;

    typedef struct packed {
        logic is_add;
        logic is_sub;
        logic is_xor;
        logic is_or;
        logic is_and;
        logic is_sll;
        logic is_slt;
        logic is_sltu;
        logic is_srl;
        logic is_sra;
    } alu_op_t;

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: combinational RV32I OP / OP-IMM decoder.
//   opcode, funct3, funct7 : instruction fields (instr[6:0], [14:12], [31:25])
//   legal                  : encoding is a supported OP or OP-IMM instruction
//   ops                    : one-hot operation flags, all zero when not legal
//   is_imm                 : operand B comes from the I-type immediate
// Only the fields the decode depends on are ported in, so the rest of the
// instruction word does not dangle inside this block.
module alu_decoder
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic       legal,
    output alu_op_t    ops,
    output logic       is_imm
);

    // Decode to one-hot flags. Everything defaults to "illegal, no operation"
    // so any encoding not explicitly listed falls out with all flags low.
    always_comb begin
        legal  = 1'b0;
        ops    = '0;
        is_imm = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    legal = 1'b1;
                    case (funct3)
                        F3_ADD:  ops.is_add  = 1'b1;
                        F3_SLL:  ops.is_sll  = 1'b1;
                        F3_SLT:  ops.is_slt  = 1'b1;
                        F3_SLTU: ops.is_sltu = 1'b1;
                        F3_XOR:  ops.is_xor  = 1'b1;
                        F3_SRL:  ops.is_srl  = 1'b1;
                        F3_OR:   ops.is_or   = 1'b1;
                        default: ops.is_and  = 1'b1;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    case (funct3)
                        F3_ADD: begin
                            legal      = 1'b1;
                            ops.is_sub = 1'b1;
                        end
                        F3_SRL: begin
                            legal      = 1'b1;
                            ops.is_sra = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            OPC_OP_IMM: begin
                is_imm = 1'b1;
                // Only the shifts reuse the funct7 bits; for everything else
                // instr[31:25] is part of the immediate and is ignored here.
                case (funct3)
                    F3_ADD:  begin legal = 1'b1; ops.is_add  = 1'b1; end
                    F3_SLT:  begin legal = 1'b1; ops.is_slt  = 1'b1; end
                    F3_SLTU: begin legal = 1'b1; ops.is_sltu = 1'b1; end
                    F3_XOR:  begin legal = 1'b1; ops.is_xor  = 1'b1; end
                    F3_OR:   begin legal = 1'b1; ops.is_or   = 1'b1; end
                    F3_AND:  begin legal = 1'b1; ops.is_and  = 1'b1; end
                    F3_SLL: begin
                        if (funct7 == F7_BASE) begin
                            legal      = 1'b1;
                            ops.is_sll = 1'b1;
                        end
                    end
                    default: begin
                        if (funct7 == F7_BASE) begin
                            legal      = 1'b1;
                            ops.is_srl = 1'b1;
                        end else if (funct7 == F7_ALT) begin
                            legal      = 1'b1;
                            ops.is_sra = 1'b1;
                        end
                    end
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: issue stage between fetch and the ALU for RV32I OP / OP-IMM.
//   clk, resetn             : clock, asynchronous active-low reset
//   instr/instr_valid/ready : fetch handshake; ready only while idle
//   flush                   : abandon the in-flight instruction
//   rs1_addr/rs2_addr       : register file read addresses (combinational)
//   rs1_data/rs2_data       : register file read data, sampled on accept
//   alu_rs1/alu_rs2/shamt   : registered ALU operands
//   is_*                    : registered one-hot ALU operation flags
//   alu_valid/alu_ready     : ALU request and result-available handshake
//   alu_out                 : ALU result
//   wb_valid/wb_rd/wb_data  : one-cycle writeback pulse
//   illegal                 : one-cycle pulse for an unsupported encoding
module alu_issue
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [31:0]     instr,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic            flush,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] alu_rs1,
    output logic [XLEN-1:0] alu_rs2,
    output logic [4:0]      alu_shamt,
    output logic            is_add,
    output logic            is_sub,
    output logic            is_xor,
    output logic            is_or,
    output logic            is_and,
    output logic            is_sll,
    output logic            is_slt,
    output logic            is_sltu,
    output logic            is_srl,
    output logic            is_sra,
    output logic            alu_valid,
    input  logic            alu_ready,
    input  logic [XLEN-1:0] alu_out,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            illegal
);

    issue_state_t    state;
    alu_op_t         ops_q;
    alu_op_t         dec_ops;
    logic            dec_legal;
    logic            dec_is_imm;
    logic            accept;
    logic            alu_valid_q;
    logic            wb_valid_q;
    logic [XLEN-1:0] imm_sext;

    alu_decoder u_decoder (
        .opcode (instr[6:0]),
        .funct3 (instr[14:12]),
        .funct7 (instr[31:25]),
        .legal  (dec_legal),
        .ops    (dec_ops),
        .is_imm (dec_is_imm)
    );

    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];
    assign imm_sext = {{(XLEN-12){instr[31]}}, instr[31:20]};

    // A flush in IDLE blocks acceptance for that cycle.
    assign accept = instr_valid && instr_ready && !flush;

    // The request and writeback pulses are registered, but flush must kill
    // them in the very cycle it is raised, so they are masked on the way out.
    assign alu_valid = alu_valid_q && !flush;
    assign wb_valid  = wb_valid_q && !flush;

    assign is_add  = ops_q.is_add;
    assign is_sub  = ops_q.is_sub;
    assign is_xor  = ops_q.is_xor;
    assign is_or   = ops_q.is_or;
    assign is_and  = ops_q.is_and;
    assign is_sll  = ops_q.is_sll;
    assign is_slt  = ops_q.is_slt;
    assign is_sltu = ops_q.is_sltu;
    assign is_srl  = ops_q.is_srl;
    assign is_sra  = ops_q.is_sra;

    // Issue FSM with registered outputs. instr_ready is registered too and
    // tracks "next state is IDLE", so it is low in reset and rises on the
    // first clock afterwards. Operand and flag registers are only loaded on
    // accept and otherwise hold; alu_valid is what qualifies them.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            instr_ready <= 1'b0;
            alu_valid_q <= 1'b0;
            wb_valid_q  <= 1'b0;
            illegal     <= 1'b0;
            alu_rs1     <= '0;
            alu_rs2     <= '0;
            alu_shamt   <= '0;
            ops_q       <= '0;
            wb_rd       <= '0;
            wb_data     <= '0;
        end else begin
            alu_valid_q <= 1'b0;
            wb_valid_q  <= 1'b0;
            illegal     <= 1'b0;
            case (state)
                IDLE: begin
                    instr_ready <= 1'b1;
                    if (accept) begin
                        if (dec_legal) begin
                            alu_rs1     <= rs1_data;
                            alu_rs2     <= dec_is_imm ? imm_sext : rs2_data;
                            alu_shamt   <= dec_is_imm ? instr[24:20] : rs2_data[4:0];
                            ops_q       <= dec_ops;
                            wb_rd       <= instr[11:7];
                            alu_valid_q <= 1'b1;
                            instr_ready <= 1'b0;
                            state       <= ISSUE;
                        end else begin
                            ops_q   <= '0;
                            illegal <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    instr_ready <= flush;
                    state       <= flush ? IDLE : WAIT;
                end
                WAIT: begin
                    // flush wins over a result arriving in the same cycle
                    if (flush) begin
                        instr_ready <= 1'b1;
                        state       <= IDLE;
                    end else if (alu_ready) begin
                        wb_data    <= alu_out;
                        wb_valid_q <= 1'b1;
                        state      <= WB;
                    end
                end
                WB: begin
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
